// File: rtl/pcie_dma_pkg.sv
// Shared types and constants for the PCIe read-DMA master.
package pcie_dma_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DATA_W_DEF     = 512;
    localparam int unsigned BEAT_BYTES     = DATA_W_DEF / 8;
    localparam int unsigned ARSIZE_VAL     = $clog2(BEAT_BYTES);
    localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
    localparam int unsigned PAGE_4K        = 4096;

endpackage

// File: rtl/axis_skid.sv
// Two-entry skid buffer between the AXI R channel and the AXI-Stream output.
module axis_skid #(
    parameter int unsigned W = 513
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign in_ready  = (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pcie_read_dma.sv
// Read-DMA master: splits a beat-count request into 4 KB-safe AXI4 INCR bursts
// with bounded outstanding reads and streams the returned data on AXI-Stream.
module pcie_read_dma
    import pcie_dma_pkg::*;
#(
    parameter int unsigned ADDR_W    = 64,
    parameter int unsigned DATA_W    = DATA_W_DEF,
    parameter int unsigned LEN_W     = 32,
    parameter int unsigned MAX_BURST = 16,
    parameter int unsigned MAX_OUTST = 2,
    parameter int unsigned ID_W      = 4,
    parameter int unsigned AXI_ID    = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [LEN_W-1:0]  num_beats,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] M_AXI_ARADDR,
    output logic [7:0]        M_AXI_ARLEN,
    output logic [2:0]        M_AXI_ARSIZE,
    output logic [1:0]        M_AXI_ARBURST,
    output logic [ID_W-1:0]   M_AXI_ARID,
    output logic [2:0]        M_AXI_ARPROT,
    output logic              M_AXI_ARLOCK,
    output logic [3:0]        M_AXI_ARCACHE,
    output logic [3:0]        M_AXI_ARQOS,
    output logic              M_AXI_ARVALID,
    input  logic              M_AXI_ARREADY,
    input  logic [DATA_W-1:0] M_AXI_RDATA,
    input  logic [1:0]        M_AXI_RRESP,
    input  logic              M_AXI_RLAST,
    input  logic              M_AXI_RVALID,
    output logic              M_AXI_RREADY,
    output logic [DATA_W-1:0] AXIS_TDATA,
    output logic              AXIS_TVALID,
    output logic              AXIS_TLAST,
    input  logic              AXIS_TREADY
);

    localparam int unsigned BYTES = DATA_W / 8;
    localparam int unsigned OFFS  = $clog2(BYTES);
    localparam int unsigned OUT_W = 4;
    localparam int unsigned BL_W  = 9;
    localparam int unsigned SK_W  = DATA_W + 1;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ar_addr;
    logic [LEN_W-1:0]  ar_rem;
    logic [LEN_W-1:0]  r_rem;
    logic [OUT_W-1:0]  outst;
    logic [BL_W-1:0]   ar_blen;
    logic [7:0]        arlen_q;
    logic              arvalid_q;
    logic              busy_q;
    logic              done_q;
    logic              error_q;

    logic [12:0]       to_4k_bytes_c;
    logic [12:0]       to_4k_beats_c;
    logic [LEN_W-1:0]  blen_c;
    logic              issue_c;
    logic              ar_hs_c;
    logic              r_hs_c;
    logic              r_last_hs_c;

    logic              sk_in_ready;
    logic              sk_out_valid;
    logic [SK_W-1:0]   sk_out_data;

    assign M_AXI_ARADDR  = ar_addr;
    assign M_AXI_ARLEN   = arlen_q;
    assign M_AXI_ARSIZE  = 3'(OFFS);
    assign M_AXI_ARBURST = AXI_BURST_INCR;
    assign M_AXI_ARID    = ID_W'(AXI_ID);
    assign M_AXI_ARPROT  = 3'b000;
    assign M_AXI_ARLOCK  = 1'b0;
    assign M_AXI_ARCACHE = 4'b0000;
    assign M_AXI_ARQOS   = 4'b0000;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = busy_q & sk_in_ready;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;

    assign ar_hs_c     = arvalid_q & M_AXI_ARREADY;
    assign r_hs_c      = M_AXI_RVALID & M_AXI_RREADY;
    assign r_last_hs_c = r_hs_c & M_AXI_RLAST;
    assign issue_c     = (state == RUN) && !arvalid_q && (ar_rem != '0)
                         && (outst < OUT_W'(MAX_OUTST));

    // Burst length: smallest of max burst, remaining beats and beats left in the 4 KB page.
    always_comb begin
        to_4k_bytes_c = 13'(PAGE_4K) - {1'b0, ar_addr[11:0]};
        to_4k_beats_c = to_4k_bytes_c >> OFFS;
        blen_c        = LEN_W'(MAX_BURST);
        if (ar_rem < blen_c) begin
            blen_c = ar_rem;
        end
        if (LEN_W'(to_4k_beats_c) < blen_c) begin
            blen_c = LEN_W'(to_4k_beats_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_beats != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if ((ar_rem == '0) && (outst == '0) && (r_rem == '0)
                    && !sk_out_valid && !arvalid_q) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // AR generator, outstanding-burst and beat counters, status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            ar_addr   <= '0;
            ar_rem    <= '0;
            r_rem     <= '0;
            outst     <= '0;
            ar_blen   <= '0;
            arlen_q   <= '0;
            arvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == RUN);
            done_q <= (state == DONE);

            if ((state == IDLE) && start) begin
                error_q <= 1'b0;
                ar_addr <= start_addr & ~ADDR_W'(BYTES - 1);
                ar_rem  <= num_beats;
                r_rem   <= num_beats;
            end

            if (issue_c) begin
                arvalid_q <= 1'b1;
                arlen_q   <= 8'(blen_c - LEN_W'(1));
                ar_blen   <= BL_W'(blen_c);
            end

            if (ar_hs_c) begin
                arvalid_q <= 1'b0;
                ar_addr   <= ar_addr + (ADDR_W'(ar_blen) << OFFS);
                ar_rem    <= ar_rem - LEN_W'(ar_blen);
            end

            case ({ar_hs_c, r_last_hs_c})
                2'b10:   outst <= outst + OUT_W'(1);
                2'b01:   outst <= outst - OUT_W'(1);
                default: outst <= outst;
            endcase

            if (r_hs_c) begin
                r_rem <= r_rem - LEN_W'(1);
                if (M_AXI_RRESP != 2'b00) begin
                    error_q <= 1'b1;
                end
            end
        end
    end

    // TLAST marks the final beat of the whole request, not of each burst.
    axis_skid #(
        .W (SK_W)
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (M_AXI_RVALID & busy_q),
        .in_ready  (sk_in_ready),
        .in_data   ({(r_rem == LEN_W'(1)), M_AXI_RDATA}),
        .out_valid (sk_out_valid),
        .out_ready (AXIS_TREADY),
        .out_data  (sk_out_data)
    );

    assign AXIS_TVALID = sk_out_valid;
    assign AXIS_TLAST  = sk_out_data[DATA_W];
    assign AXIS_TDATA  = sk_out_data[DATA_W-1:0];

endmodule

// File: tb/tb_pcie_read_dma.sv
// Directed bench for pcie_read_dma with a pcie_source-style slave returning RDATA = beat address.
module tb_pcie_read_dma;

    typedef struct packed {
        logic [63:0]      addr;
        logic [31:0]      beats;
        logic             rnd;
        logic [1:0]       n_ar;
        logic [2:0][63:0] ar_a;
        logic [2:0][7:0]  ar_l;
    } vec_t;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
    } slv_ar_t;

    typedef struct packed {
        logic [63:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
    } ar_rec_t;

    typedef struct packed {
        logic        last;
        logic [63:0] d;
    } t_rec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [63:0]  start_addr = '0;
    logic [31:0]  num_beats = '0;
    logic         busy, done, error;
    logic [63:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic [3:0]   arid;
    logic [2:0]   arprot;
    logic         arlock;
    logic [3:0]   arcache, arqos;
    logic         arvalid;
    logic         arready = 1'b0;
    logic [511:0] rdata = '0;
    logic [1:0]   rresp = 2'b00;
    logic         rlast = 1'b0;
    logic         rvalid = 1'b0;
    logic         rready;
    logic [511:0] tdata;
    logic         tvalid, tlast;
    logic         tready = 1'b0;

    bit           rnd = 1'b0;
    bit           inject = 1'b0;
    slv_ar_t      pend[$];
    ar_rec_t      ar_log[$];
    t_rec_t       t_log[$];
    int           beat_idx = 0;
    int           r_cnt = 0;
    int           done_cnt = 0;
    int           outst_m = 0;
    int           outst_max = 0;
    bit           arv_seen = 1'b0;
    int           n_cmp = 0;
    int           n_fail = 0;
    vec_t         vecs[6];

    pcie_read_dma dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .start_addr    (start_addr),
        .num_beats     (num_beats),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .M_AXI_ARADDR  (araddr),
        .M_AXI_ARLEN   (arlen),
        .M_AXI_ARSIZE  (arsize),
        .M_AXI_ARBURST (arburst),
        .M_AXI_ARID    (arid),
        .M_AXI_ARPROT  (arprot),
        .M_AXI_ARLOCK  (arlock),
        .M_AXI_ARCACHE (arcache),
        .M_AXI_ARQOS   (arqos),
        .M_AXI_ARVALID (arvalid),
        .M_AXI_ARREADY (arready),
        .M_AXI_RDATA   (rdata),
        .M_AXI_RRESP   (rresp),
        .M_AXI_RLAST   (rlast),
        .M_AXI_RVALID  (rvalid),
        .M_AXI_RREADY  (rready),
        .AXIS_TDATA    (tdata),
        .AXIS_TVALID   (tvalid),
        .AXIS_TLAST    (tlast),
        .AXIS_TREADY   (tready)
    );

    always #5 clk = ~clk;

    // Slave and stream monitor: sample handshakes with pre-edge values.
    always @(posedge clk) begin
        if (reset) begin
            pend.delete();
            beat_idx = 0;
            outst_m  = 0;
        end else begin
            if (start) begin
                outst_max = 0;
                r_cnt     = 0;
                arv_seen  = 1'b0;
            end
            if (rvalid && rready) begin
                r_cnt++;
                if (rlast) begin
                    void'(pend.pop_front());
                    beat_idx = 0;
                    outst_m--;
                end else begin
                    beat_idx++;
                end
            end
            if (arvalid && arready) begin
                pend.push_back({araddr, arlen});
                ar_log.push_back({araddr, arlen, arsize, arburst});
                outst_m++;
            end
            if (outst_m > outst_max) outst_max = outst_m;
            if (arvalid) arv_seen = 1'b1;
            if (tvalid && tready) t_log.push_back({tlast, tdata[63:0]});
            if (done) done_cnt++;
        end
    end

    // Slave drive on the falling edge.
    always @(negedge clk) begin
        arready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        if (pend.size() != 0 && (!rnd || $urandom_range(0, 3) != 0)) begin
            rvalid = 1'b1;
            rdata  = 512'(pend[0].addr + 64'(beat_idx) * 64'd64);
            rlast  = (beat_idx == int'(pend[0].len));
            rresp  = (inject && r_cnt == 1) ? 2'b10 : 2'b00;
        end else begin
            rvalid = 1'b0;
            rdata  = '0;
            rlast  = 1'b0;
            rresp  = 2'b00;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start(input logic [63:0] a, input logic [31:0] n);
        start      = 1'b1;
        start_addr = a;
        num_beats  = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int db, input string nm);
        int cyc;
        cyc = 0;
        while (done_cnt == db && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        chk({nm, "_timeout"}, 64'(done_cnt == db), 64'd0);
    endtask

    task automatic run_vec(input vec_t v, input int id);
        int ab, tb0, db;
        logic [63:0] base;
        ab  = ar_log.size();
        tb0 = t_log.size();
        db  = done_cnt;
        rnd = v.rnd;
        @(negedge clk);
        pulse_start(v.addr, v.beats);
        wait_done(db, $sformatf("v%0d", id));
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_n_ar", id), 64'(ar_log.size() - ab), 64'(v.n_ar));
        for (int i = 0; i < int'(v.n_ar); i++) begin
            if (ab + i < ar_log.size()) begin
                chk($sformatf("v%0d_araddr%0d", id, i), ar_log[ab+i].a, v.ar_a[i]);
                chk($sformatf("v%0d_arlen%0d", id, i), 64'(ar_log[ab+i].l), 64'(v.ar_l[i]));
                chk($sformatf("v%0d_arsize%0d", id, i), 64'(ar_log[ab+i].s), 64'd6);
                chk($sformatf("v%0d_arburst%0d", id, i), 64'(ar_log[ab+i].b), 64'd1);
            end
        end
        chk($sformatf("v%0d_n_beats", id), 64'(t_log.size() - tb0), 64'(v.beats));
        base = v.addr & ~64'h3F;
        for (int i = 0; i < int'(v.beats); i++) begin
            if (tb0 + i < t_log.size()) begin
                chk($sformatf("v%0d_tdata%0d", id, i), t_log[tb0+i].d, base + 64'(i) * 64'd64);
                chk($sformatf("v%0d_tlast%0d", id, i), 64'(t_log[tb0+i].last),
                    64'(i == int'(v.beats) - 1));
            end
        end
        chk($sformatf("v%0d_done_cnt", id), 64'(done_cnt - db), 64'd1);
        chk($sformatf("v%0d_busy_after", id), 64'(busy), 64'd0);
        chk($sformatf("v%0d_outst_ok", id), 64'(outst_max <= 2), 64'd1);
        rnd = 1'b0;
    endtask

    initial begin
        int db, tb0, ab;
        vecs[0] = '{addr: 64'h1000, beats: 32'd4,  rnd: 1'b0, n_ar: 2'd1,
                    ar_a: {64'h0, 64'h0, 64'h1000}, ar_l: {8'd0, 8'd0, 8'd3}};
        vecs[1] = '{addr: 64'h0FC0, beats: 32'd3,  rnd: 1'b0, n_ar: 2'd2,
                    ar_a: {64'h0, 64'h1000, 64'h0FC0}, ar_l: {8'd0, 8'd1, 8'd0}};
        vecs[2] = '{addr: 64'h0,    beats: 32'd40, rnd: 1'b0, n_ar: 2'd3,
                    ar_a: {64'h800, 64'h400, 64'h0}, ar_l: {8'd7, 8'd15, 8'd15}};
        vecs[3] = '{addr: 64'h0,    beats: 32'd40, rnd: 1'b1, n_ar: 2'd3,
                    ar_a: {64'h800, 64'h400, 64'h0}, ar_l: {8'd7, 8'd15, 8'd15}};
        vecs[4] = '{addr: 64'h1010, beats: 32'd2,  rnd: 1'b0, n_ar: 2'd1,
                    ar_a: {64'h0, 64'h0, 64'h1000}, ar_l: {8'd0, 8'd0, 8'd1}};
        vecs[5] = '{addr: 64'h0F80, beats: 32'd20, rnd: 1'b1, n_ar: 2'd3,
                    ar_a: {64'h1400, 64'h1000, 64'h0F80}, ar_l: {8'd1, 8'd15, 8'd1}};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({busy, done, error, arvalid, rready, tvalid, tlast}), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // start -> ARVALID latency of two cycles
        db = done_cnt;
        pulse_start(64'h2000, 32'd1);
        chk("lat_arvalid_c1", 64'(arvalid), 64'd0);
        chk("lat_busy_c1", 64'(busy), 64'd1);
        @(negedge clk);
        chk("lat_arvalid_c2", 64'(arvalid), 64'd1);
        chk("lat_araddr", araddr, 64'h2000);
        chk("lat_arlen", 64'(arlen), 64'd0);
        wait_done(db, "lat");
        repeat (2) @(negedge clk);

        // Zero-length request
        db = done_cnt;
        pulse_start(64'h3000, 32'd0);
        chk("zero_done_c1", 64'(done), 64'd0);
        chk("zero_busy_c1", 64'(busy), 64'd0);
        @(negedge clk);
        chk("zero_done_c2", 64'(done), 64'd1);
        @(negedge clk);
        chk("zero_done_c3", 64'(done), 64'd0);
        chk("zero_no_ar", 64'(arv_seen), 64'd0);
        chk("zero_done_cnt", 64'(done_cnt - db), 64'd1);

        // Start while busy is ignored
        db  = done_cnt;
        ab  = ar_log.size();
        tb0 = t_log.size();
        pulse_start(64'h0, 32'd8);
        repeat (3) @(negedge clk);
        pulse_start(64'h3000, 32'd4);
        wait_done(db, "busy_start");
        repeat (4) @(negedge clk);
        chk("busy_start_n_ar", 64'(ar_log.size() - ab), 64'd1);
        if (ab < ar_log.size()) chk("busy_start_arlen", 64'(ar_log[ab].l), 64'd7);
        chk("busy_start_beats", 64'(t_log.size() - tb0), 64'd8);
        chk("busy_start_done_cnt", 64'(done_cnt - db), 64'd1);

        // RRESP error on beat 2 is sticky until the next start
        db     = done_cnt;
        tb0    = t_log.size();
        inject = 1'b1;
        pulse_start(64'h1000, 32'd4);
        wait_done(db, "err");
        inject = 1'b0;
        repeat (3) @(negedge clk);
        chk("err_set", 64'(error), 64'd1);
        chk("err_beats", 64'(t_log.size() - tb0), 64'd4);
        db = done_cnt;
        pulse_start(64'h1000, 32'd1);
        chk("err_clear_on_start", 64'(error), 64'd0);
        wait_done(db, "err2");
        chk("err_clean_run", 64'(error), 64'd0);
        repeat (2) @(negedge clk);

        // Table-driven transfers
        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        // Reset in the middle of a transfer
        pulse_start(64'h0, 32'd40);
        repeat (10) @(negedge clk);
        chk("mid_busy_before", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outputs", 64'({busy, done, error, arvalid, rready, tvalid, tlast}), 64'd0);
        chk("mid_reset_tdata", tdata[63:0], 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run_vec(vecs[0], 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
